latch_capture_reader: RTL and testbench



---
 rtl/latch_capture_reader_pkg.sv | 16 +
 rtl/latch_capture_reader_sync_fifo.sv | 54 +++++
 rtl/latch_capture_reader.sv | 96 +++++++++
 tb/tb_latch_capture_reader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/latch_capture_reader_pkg.sv
// Shared types for the latch capture reader: FSM state encoding and pointer sizing.
package latch_rd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPEN    = 2'd1,
    SETTLE  = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  // Pointer width for a power-of-two FIFO; never narrower than one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/latch_capture_reader_sync_fifo.sv
// Small registered FIFO; a push is accepted when full only if a pop frees a slot the same cycle.
module sync_fifo
  import latch_rd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic                    full,
  output logic                    empty,
  output logic [ptr_w(DEPTH):0]   count,
  output logic [WIDTH-1:0]        head
);

  localparam int PW = ptr_w(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               rd_ptr;
  logic [PW-1:0]               wr_ptr;
  logic                        do_push;
  logic                        do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/latch_capture_reader.sv
// Samples a latch bank a fixed settle time after it closes and queues the value for a
// valid/ready consumer; captures that find the queue full are counted and dropped.
module latch_capture_reader
  import latch_rd_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 4,
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             latch_en,
  input  logic [WIDTH-1:0] latch_q,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] overrun_cnt
);

  localparam int PW   = ptr_w(DEPTH);
  localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  state_t            state;
  logic              en_d;
  logic              en_fall;
  logic [SC_W-1:0]   settle_cnt;
  logic              capture;
  logic              pop;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [PW:0]       fifo_count;

  assign en_fall   = en_d & ~latch_en;
  assign capture   = (state == CAPTURE);
  assign pop       = out_ready & ~fifo_empty;
  // A pop in the capture cycle makes room, so only a full FIFO with no pop drops.
  assign drop      = capture & fifo_full & ~pop;
  assign out_valid = (fifo_count != '0);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      en_d        <= 1'b0;
      settle_cnt  <= '0;
      overrun_cnt <= '0;
    end else begin
      en_d <= latch_en;
      if (drop && (overrun_cnt != '1))
        overrun_cnt <= overrun_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (latch_en)
            state <= OPEN;
        end
        OPEN: begin
          if (en_fall) begin
            state      <= SETTLE;
            settle_cnt <= SC_W'(SETTLE_CYC - 1);
          end
        end
        SETTLE: begin
          if (latch_en)
            state <= OPEN;
          else if (settle_cnt == '0)
            state <= CAPTURE;
          else
            settle_cnt <= settle_cnt - 1'b1;
        end
        CAPTURE: begin
          state <= latch_en ? OPEN : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (capture),
    .push_data (latch_q),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (out_data)
  );

endmodule

// File: tb/tb_latch_capture_reader.sv
// Scoreboard bench: stimulus queues expected beats, a negedge monitor checks every accepted beat.
module tb_latch_capture_reader;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int SETTLE_CYC = 2;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             latch_en;
  logic [WIDTH-1:0] latch_q;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             busy;
  logic [CNT_W-1:0] overrun_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  logic [WIDTH-1:0] exp_q[$];

  always #5 clk = ~clk;

  latch_capture_reader #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .SETTLE_CYC (SETTLE_CYC),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .latch_en    (latch_en),
    .latch_q     (latch_q),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .busy        (busy),
    .overrun_cnt (overrun_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Open the latch with value v for two cycles, close it, and wait until capture has completed.
  task automatic close_event(input logic [WIDTH-1:0] v);
    latch_en = 1'b1;
    latch_q  = v;
    tick(2);
    latch_en = 1'b0;
    tick(SETTLE_CYC + 2);
  endtask

  // Monitor: every accepted beat must match the scoreboard head; a stalled head must hold.
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data  = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_data", {24'd0, out_data}, {24'd0, prev_data});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_beat", {24'd0, out_data}, 32'hFFFF_FFFF);
        else check("beat_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
      end
      prev_stall <= out_valid && !out_ready;
      prev_data  <= out_data;
    end
  end

  initial begin
    logic [19:0] bp_pat;
    bp_pat    = 20'b0110_1001_0010_1100_0101;
    rst       = 1'b1;
    latch_en  = 1'b0;
    latch_q   = '0;
    out_ready = 1'b1;
    tick(2);
    @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", {24'd0, out_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overrun", {24'd0, overrun_cnt}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick(1);

    // Basic capture and latency.
    latch_en = 1'b1;
    latch_q  = 8'hA5;
    tick(3);
    latch_en = 1'b0;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("lat_wait", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("lat_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("one_beat", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;

    // Settle abort, then a clean close.
    latch_en = 1'b1;
    latch_q  = 8'h3C;
    tick(2);
    latch_en = 1'b0;
    tick(1);
    latch_en = 1'b1;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort_novalid", {31'd0, out_valid}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
    end
    exp_q.push_back(8'h3C);
    latch_en = 1'b0;
    tick(6);
    check("abort_drained", exp_q.size(), 32'd0);

    // Fill and overrun.
    out_ready = 1'b0;
    for (int v = 1; v <= 6; v++) begin
      if (v <= DEPTH) exp_q.push_back(WIDTH'(v));
      close_event(WIDTH'(v));
    end
    @(negedge clk);
    check("fill_overrun", {24'd0, overrun_cnt}, 32'd2);
    check("fill_head", {24'd0, out_data}, 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      check("drain_nogap", {31'd0, out_valid}, 32'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("drain_empty", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;

    // Full FIFO with a pop landing in the capture cycle.
    out_ready = 1'b0;
    for (int v = 8'h11; v <= 8'h14; v++) begin
      exp_q.push_back(WIDTH'(v));
      close_event(WIDTH'(v));
    end
    latch_en = 1'b1;
    latch_q  = 8'h15;
    tick(2);
    latch_en = 1'b0;
    tick(SETTLE_CYC + 1);
    out_ready = 1'b1;
    exp_q.push_back(8'h15);
    tick(1);
    out_ready = 1'b0;
    tick(1);
    @(negedge clk);
    check("pp_overrun", {24'd0, overrun_cnt}, 32'd2);
    check("pp_head", {24'd0, out_data}, 32'h12);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      check("pp_count", {31'd0, out_valid}, 32'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("pp_empty", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;

    // Backpressure stability.
    out_ready = 1'b0;
    for (int v = 8'h21; v <= 8'h23; v++) begin
      exp_q.push_back(WIDTH'(v));
      close_event(WIDTH'(v));
    end
    for (int i = 0; i < 20; i++) begin
      out_ready = bp_pat[i];
      tick(1);
    end
    out_ready = 1'b1;
    tick(3);
    check("bp_drained", exp_q.size(), 32'd0);

    // Reset during settle with entries queued and the latch held open through reset.
    out_ready = 1'b0;
    exp_q.push_back(8'h31);
    close_event(8'h31);
    exp_q.push_back(8'h32);
    close_event(8'h32);
    latch_en = 1'b1;
    latch_q  = 8'h33;
    tick(2);
    latch_en = 1'b0;
    tick(1);
    rst      = 1'b1;
    latch_en = 1'b1;
    exp_q.delete();
    tick(1);
    @(negedge clk);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_overrun", {24'd0, overrun_cnt}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_open", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_quiet", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
    end
    latch_q  = 8'h44;
    latch_en = 1'b0;
    exp_q.push_back(8'h44);
    tick(6);
    check("final_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
